// File: rtl/sigmoid_layer_seq.sv
// sigmoid_layer_seq
//
// Streams one vector of Q16.16 pre-activations from a source memory through
// an external 2-stage sigmoid unit and writes each result to a destination
// memory. Per job it writes either sigma(x) or the backprop derivative
// sigma(x)*(1-sigma(x)).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                job request, sampled only in IDLE
//   deriv, src_base,
//   dst_base, len        job mode / bases / element count, latched at start
//   abort                cancel the job in progress (RUN or DRAIN)
//   busy                 job in progress (RUN, DRAIN)
//   done                 one-cycle pulse on normal completion
//   rd_en, rd_addr       source read strobe / address
//   rd_data              source data, valid one cycle after rd_en
//   sig_en, sig_in       sigmoid unit enable / input (owned during a job)
//   sig_out              sigmoid unit output, two enabled clocks after sig_in
//   wr_en, wr_addr,
//   wr_data              destination write strobe / address / data
//
// Job handshake: start is a level sampled only while IDLE; when sampled high
// the job parameters are captured in that same cycle and later changes on
// them are ignored. done is a single-cycle pulse in FIN after the last
// write; an aborted job returns to IDLE without done. There is no
// backpressure on either memory: rd_en and wr_en are unconditional strobes.

module sigmoid_layer_seq #(
  parameter int AW      = 16,
  parameter int LW      = 16,
  parameter int MEM_LAT = 1,
  parameter int SIG_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          deriv,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [LW-1:0] len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data,
  output logic          sig_en,
  output logic [31:0]   sig_in,
  input  logic [31:0]   sig_out,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data
);

  // Valid pipe covers the memory read plus the sigmoid unit latency.
  localparam int PIPE_W = MEM_LAT + SIG_LAT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       rc_q, rc_d;
  logic [LW-1:0]       wc_q, wc_d;
  logic [LW-1:0]       len_q, len_d;
  logic [AW-1:0]       src_q, src_d;
  logic [AW-1:0]       dst_q, dst_d;
  logic                deriv_q, deriv_d;
  logic [PIPE_W-1:0]   vp_q, vp_d;
  logic [63:0]         prod;
  logic [31:0]         deriv_res;
  logic                active;

  // Output decode: everything is derived from registered state so an
  // asynchronous reset forces all outputs to zero without a clock edge.
  always_comb begin
    active  = (state_q == S_RUN) || (state_q == S_DRAIN);
    busy    = active;
    done    = (state_q == S_FIN);
    rd_en   = (state_q == S_RUN);
    sig_en  = active;
    wr_en   = vp_q[PIPE_W-1];
    rd_addr = rd_en ? (src_q + AW'(rc_q)) : '0;
    wr_addr = wr_en ? (dst_q + AW'(wc_q)) : '0;
    sig_in  = sig_en ? rd_data : '0;
    // Unsigned 64-bit product, no clamp: sigma = 1.0 gives 0, and sigma
    // above 1.0 wraps in the 64-bit subtraction as the low bits dictate.
    prod      = {32'd0, sig_out} * (64'h1_0000 - {32'd0, sig_out});
    deriv_res = 32'(prod >> 16);
    if (!wr_en)       wr_data = '0;
    else if (deriv_q) wr_data = deriv_res;
    else              wr_data = sig_out;
  end

  // Next-state and datapath register update.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    wc_d    = wc_q;
    len_d   = len_q;
    src_d   = src_q;
    dst_d   = dst_q;
    deriv_d = deriv_q;
    vp_d    = vp_q;

    // The sigmoid unit only advances while enabled, so the valid pipe
    // shifts under the same condition to stay aligned with its data.
    if (sig_en) vp_d = {vp_q[PIPE_W-2:0], rd_en};
    if (wr_en)  wc_d = wc_q + LW'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d   = len;
            src_d   = src_base;
            dst_d   = dst_base;
            deriv_d = deriv;
            rc_d    = '0;
            wc_d    = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_RUN: begin
        rc_d = rc_q + LW'(1);
        if (rc_q == len_q - LW'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_en && (wc_q == len_q - LW'(1))) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a final write in this cycle:
    // that write still leaves through wr_en, but FIN (and done) is skipped.
    if (active && abort) begin
      state_d = S_IDLE;
      vp_d    = '0;
      rc_d    = '0;
      wc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rc_q    <= '0;
      wc_q    <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      deriv_q <= 1'b0;
      vp_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      wc_q    <= wc_d;
      len_q   <= len_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      deriv_q <= deriv_d;
      vp_q    <= vp_d;
    end
  end

endmodule

// File: tb/tb_sigmoid_layer_seq.sv
// tb_sigmoid_layer_seq
//
// Bench for sigmoid_layer_seq. Provides a 1-cycle-latency source memory and
// a 2-stage enabled sigmoid unit (hard sigmoid: 0.5 + x/4 clamped to [0,1]),
// logs every read, write, done and busy cycle relative to the cycle the job
// was started, and checks the logs against expectations built from the job
// timing rules with plain arithmetic.

module tb_sigmoid_layer_seq;

  localparam int AW = 16;
  localparam int LW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, deriv, abort;
  logic [AW-1:0] src_base, dst_base;
  logic [LW-1:0] len;
  logic          busy, done, rd_en, sig_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [31:0]   rd_data, sig_in, sig_out, wr_data;

  always #5 clk = ~clk;

  sigmoid_layer_seq #(.AW(AW), .LW(LW), .MEM_LAT(1), .SIG_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .deriv(deriv),
    .src_base(src_base), .dst_base(dst_base), .len(len), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .sig_en(sig_en), .sig_in(sig_in), .sig_out(sig_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // ---------------- environment models ----------------
  logic [31:0] src_mem [0:65535];
  logic [31:0] s1, s2;

  function automatic logic [31:0] hsig(input logic [31:0] x);
    longint v;
    v = 32768 + (longint'($signed(x)) >>> 2);
    if (v < 0) v = 0;
    if (v > 65536) v = 65536;
    return 32'(v);
  endfunction

  // s is in [0, 1.0], so s*(1-s) in Q16.16 is a plain non-negative product.
  function automatic logic [31:0] dsig(input logic [31:0] s);
    longint v;
    v = longint'(s);
    return 32'((v * (65536 - v)) / 65536);
  endfunction

  always @(posedge clk) rd_data <= src_mem[rd_addr];

  always @(posedge clk) begin
    if (sig_en) begin
      s1 <= sig_in;
      s2 <= hsig(s1);
    end
  end
  assign sig_out = s2;

  // ---------------- cycle counter and monitor ----------------
  int cyc = 0;
  int job_c0 = 0;
  int n_tests = 0;
  int n_fail = 0;

  int          rd_cyc[$], wr_cyc[$], done_cyc[$], busy_cyc[$];
  logic [15:0] rd_alog[$], wr_alog[$];
  logic [31:0] wr_dlog[$];
  logic [31:0] exp_q[$];
  logic [15:0] exp_a[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int r;
    r = cyc - job_c0;
    if (rd_en) begin rd_cyc.push_back(r); rd_alog.push_back(rd_addr); end
    if (wr_en) begin wr_cyc.push_back(r); wr_alog.push_back(wr_addr); wr_dlog.push_back(wr_data); end
    if (done) done_cyc.push_back(r);
    if (busy) busy_cyc.push_back(r);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs;
    rd_cyc.delete(); wr_cyc.delete(); done_cyc.delete(); busy_cyc.delete();
    rd_alog.delete(); wr_alog.delete(); wr_dlog.delete();
  endtask

  // Called at a negedge; that cycle becomes cycle 0 of the job.
  task automatic start_job(input logic [15:0] sb, input logic [15:0] db,
                           input logic [15:0] l, input logic dv);
    clear_logs();
    job_c0 = cyc;
    start = 1'b1; src_base = sb; dst_base = db; len = l; deriv = dv;
    @(negedge clk);
    start = 1'b0;
    src_base = 16'($urandom); dst_base = 16'($urandom);
    len = 16'($urandom); deriv = 1'($urandom);
  endtask

  // Reference: element i is read from sb+i and written to db+i.
  task automatic build_exp(input logic [15:0] sb, input logic [15:0] db,
                           input int l, input logic dv);
    logic [31:0] s;
    exp_q.delete(); exp_a.delete();
    for (int i = 0; i < l; i++) begin
      s = hsig(src_mem[16'(sb + 16'(i))]);
      exp_q.push_back(dv ? dsig(s) : s);
      exp_a.push_back(16'(db + 16'(i)));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({busy, done, rd_en, sig_en, wr_en} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, rd_en, sig_en, wr_en}); end
    n_tests++; if ({rd_addr, wr_addr} !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", {rd_addr, wr_addr}); end
    n_tests++; if ({wr_data, sig_in} !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {wr_data, sig_in}); end
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic;
    logic [15:0] sb, db;
    logic [31:0] want [3];
    want[0] = 32'h8000; want[1] = 32'hC000; want[2] = 32'h4000;
    sb = 16'($urandom); db = 16'($urandom);
    src_mem[sb] = 32'h0; src_mem[16'(sb + 16'd1)] = 32'h10000; src_mem[16'(sb + 16'd2)] = 32'hFFFF0000;
    start_job(sb, db, 16'd3, 1'b0);
    step(8);
    n_tests++; if (wr_cyc.size() != 3) begin n_fail++; $display("FAIL basic_wr_count got %0d want 3", wr_cyc.size()); end
    for (int i = 0; i < 3 && i < wr_cyc.size(); i++) begin
      n_tests++; if (wr_cyc[i] != 4 + i) begin n_fail++; $display("FAIL basic_wr_cyc[%0d] got %0d want %0d", i, wr_cyc[i], 4 + i); end
      n_tests++; if (wr_alog[i] !== 16'(db + 16'(i))) begin n_fail++; $display("FAIL basic_wr_addr[%0d] got %h want %h", i, wr_alog[i], 16'(db + 16'(i))); end
      n_tests++; if (wr_dlog[i] !== want[i]) begin n_fail++; $display("FAIL basic_wr_data[%0d] got %h want %h", i, wr_dlog[i], want[i]); end
    end
    n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != 7) begin n_fail++; $display("FAIL basic_done got %0d pulses (first %0d) want 1 at 7", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1); end
    n_tests++; if (busy_cyc.size() != 6 || busy_cyc[0] != 1 || busy_cyc[busy_cyc.size()-1] != 6) begin n_fail++; $display("FAIL basic_busy got %0d cycles want 6 (1..6)", busy_cyc.size()); end
  endtask

  task automatic test_deriv;
    logic [15:0] sb, db;
    logic [31:0] want [4];
    want[0] = 32'h4000; want[1] = 32'h3000; want[2] = 32'h3000; want[3] = 32'h0;
    sb = 16'($urandom); db = 16'($urandom);
    src_mem[sb] = 32'h0; src_mem[16'(sb + 16'd1)] = 32'h10000;
    src_mem[16'(sb + 16'd2)] = 32'hFFFF0000; src_mem[16'(sb + 16'd3)] = 32'h50000;
    start_job(sb, db, 16'd4, 1'b1);
    step(9);
    n_tests++; if (wr_dlog.size() != 4) begin n_fail++; $display("FAIL deriv_wr_count got %0d want 4", wr_dlog.size()); end
    for (int i = 0; i < 4 && i < wr_dlog.size(); i++) begin
      n_tests++; if (wr_dlog[i] !== want[i]) begin n_fail++; $display("FAIL deriv_wr_data[%0d] got %h want %h", i, wr_dlog[i], want[i]); end
    end
    n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != 8) begin n_fail++; $display("FAIL deriv_done got %0d pulses want 1 at 8", done_cyc.size()); end
  endtask

  task automatic test_zero_len;
    start_job(16'($urandom), 16'($urandom), 16'd0, 1'($urandom));
    step(4);
    n_tests++; if (rd_cyc.size() != 0 || wr_cyc.size() != 0) begin n_fail++; $display("FAIL zero_len_access got %0d reads %0d writes want 0 0", rd_cyc.size(), wr_cyc.size()); end
    n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != 1) begin n_fail++; $display("FAIL zero_len_done got %0d pulses want 1 at 1", done_cyc.size()); end
    n_tests++; if (busy_cyc.size() != 0) begin n_fail++; $display("FAIL zero_len_busy got %0d busy cycles want 0", busy_cyc.size()); end
  endtask

  task automatic test_abort;
    logic [15:0] sb, db;
    sb = 16'($urandom); db = 16'($urandom);
    for (int i = 0; i < 8; i++) src_mem[16'(sb + 16'(i))] = $urandom;
    start_job(sb, db, 16'd8, 1'b0);
    step(4);                         // cycle 5
    abort = 1'b1;
    step(1);                         // cycle 6
    abort = 1'b0;
    n_tests++; if ({rd_en, sig_en, wr_en, busy} !== 4'b0) begin n_fail++; $display("FAIL abort_drop got %b want 0000", {rd_en, sig_en, wr_en, busy}); end
    step(1);                         // cycle 7
    n_tests++; if (wr_cyc.size() != 2 || wr_cyc[0] != 4 || wr_cyc[1] != 5) begin n_fail++; $display("FAIL abort_writes got %0d writes want 2 at 4..5", wr_cyc.size()); end
    n_tests++; if (done_cyc.size() != 0) begin n_fail++; $display("FAIL abort_done got %0d pulses want 0", done_cyc.size()); end
    // New job launched in cycle 7 from fresh bases.
    sb = 16'(sb + 16'd100); db = 16'($urandom);
    for (int i = 0; i < 3; i++) src_mem[16'(sb + 16'(i))] = 32'($urandom_range(0, 32'hC0000)) - 32'h60000;
    build_exp(sb, db, 3, 1'b1);
    start_job(sb, db, 16'd3, 1'b1);
    step(8);
    n_tests++; if (wr_cyc.size() != 3) begin n_fail++; $display("FAIL abort_next_count got %0d want 3", wr_cyc.size()); end
    for (int i = 0; i < 3 && i < wr_cyc.size(); i++) begin
      n_tests++; if (wr_cyc[i] != 4 + i || wr_alog[i] !== exp_a[i] || wr_dlog[i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_next_wr[%0d] got c%0d %h %h want c%0d %h %h", i, wr_cyc[i], wr_alog[i], wr_dlog[i], 4 + i, exp_a[i], exp_q[i]); end
    end
    n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != 7) begin n_fail++; $display("FAIL abort_next_done got %0d pulses want 1 at 7", done_cyc.size()); end
  endtask

  task automatic test_abort_last;
    start_job(16'($urandom), 16'($urandom), 16'd2, 1'b0);
    step(4);                         // cycle 5: last write
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(4);
    n_tests++; if (wr_cyc.size() != 2 || wr_cyc[1] != 5) begin n_fail++; $display("FAIL abort_last_writes got %0d writes want 2 ending at 5", wr_cyc.size()); end
    n_tests++; if (done_cyc.size() != 0) begin n_fail++; $display("FAIL abort_last_done got %0d pulses want 0", done_cyc.size()); end
  endtask

  task automatic test_wrap;
    logic [15:0] db;
    logic [15:0] want_rd [4];
    want_rd[0] = 16'hFFFE; want_rd[1] = 16'hFFFF; want_rd[2] = 16'h0000; want_rd[3] = 16'h0001;
    db = 16'($urandom);
    for (int i = 0; i < 4; i++) src_mem[want_rd[i]] = 32'($urandom_range(0, 32'hC0000)) - 32'h60000;
    build_exp(16'hFFFE, db, 4, 1'b0);
    start_job(16'hFFFE, db, 16'd4, 1'b0);
    step(1);                         // cycle 2: start with other parameters
    start = 1'b1; src_base = 16'h1234; dst_base = 16'(db + 16'h4000); len = 16'd1; deriv = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    n_tests++; if (rd_cyc.size() != 4) begin n_fail++; $display("FAIL wrap_rd_count got %0d want 4", rd_cyc.size()); end
    for (int i = 0; i < 4 && i < rd_cyc.size(); i++) begin
      n_tests++; if (rd_alog[i] !== want_rd[i] || rd_cyc[i] != 1 + i) begin n_fail++; $display("FAIL wrap_rd[%0d] got c%0d %h want c%0d %h", i, rd_cyc[i], rd_alog[i], 1 + i, want_rd[i]); end
    end
    n_tests++; if (wr_cyc.size() != 4) begin n_fail++; $display("FAIL wrap_wr_count got %0d want 4", wr_cyc.size()); end
    for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
      n_tests++; if (wr_alog[i] !== exp_a[i] || wr_dlog[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_wr[%0d] got %h %h want %h %h", i, wr_alog[i], wr_dlog[i], exp_a[i], exp_q[i]); end
    end
    n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != 8) begin n_fail++; $display("FAIL wrap_done got %0d pulses want 1 at 8", done_cyc.size()); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] sa, da, sb, db;
    sa = 16'($urandom); da = 16'($urandom); sb = 16'(sa + 16'd8); db = 16'(da + 16'h100);
    for (int i = 0; i < 2; i++) begin
      src_mem[16'(sa + 16'(i))] = 32'($urandom_range(0, 32'hC0000)) - 32'h60000;
      src_mem[16'(sb + 16'(i))] = 32'($urandom_range(0, 32'hC0000)) - 32'h60000;
    end
    build_exp(sb, db, 2, 1'b1);
    exp_q.push_front(hsig(src_mem[16'(sa + 16'd1)])); exp_a.push_front(16'(da + 16'd1));
    exp_q.push_front(hsig(src_mem[sa]));              exp_a.push_front(da);
    clear_logs();
    job_c0 = cyc;
    start = 1'b1; src_base = sa; dst_base = da; len = 16'd2; deriv = 1'b0;
    step(3);                         // cycle 3, job A busy: change parameters
    src_base = sb; dst_base = db; deriv = 1'b1;
    step(5);                         // cycle 8: job B accepted in cycle 7
    start = 1'b0;
    step(8);
    n_tests++; if (wr_cyc.size() != 4) begin n_fail++; $display("FAIL b2b_wr_count got %0d want 4", wr_cyc.size()); end
    for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
      n_tests++; if (wr_cyc[i] != (i < 2 ? 4 + i : 9 + i) || wr_alog[i] !== exp_a[i] || wr_dlog[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_wr[%0d] got c%0d %h %h want c%0d %h %h", i, wr_cyc[i], wr_alog[i], wr_dlog[i], (i < 2 ? 4 + i : 9 + i), exp_a[i], exp_q[i]); end
    end
    n_tests++; if (done_cyc.size() != 2 || done_cyc[0] != 6 || done_cyc[1] != 13) begin n_fail++; $display("FAIL b2b_done got %0d pulses want 2 at 6,13", done_cyc.size()); end
  endtask

  task automatic test_random;
    logic [15:0] sb, db;
    int l;
    logic dv;
    for (int j = 0; j < 6; j++) begin
      sb = 16'($urandom); db = 16'($urandom); l = $urandom_range(1, 12); dv = 1'($urandom);
      for (int i = 0; i < l; i++) src_mem[16'(sb + 16'(i))] = 32'($urandom_range(0, 32'hC0000)) - 32'h60000;
      build_exp(sb, db, l, dv);
      start_job(sb, db, 16'(l), dv);
      step(l + 5);
      n_tests++; if (rd_cyc.size() != l || wr_cyc.size() != l) begin n_fail++; $display("FAIL rand%0d_count got %0d reads %0d writes want %0d", j, rd_cyc.size(), wr_cyc.size(), l); end
      for (int i = 0; i < l && i < wr_cyc.size() && i < rd_cyc.size(); i++) begin
        n_tests++; if (rd_alog[i] !== 16'(sb + 16'(i)) || wr_cyc[i] != 4 + i || wr_alog[i] !== exp_a[i] || wr_dlog[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_wr[%0d] got rd %h c%0d %h %h want rd %h c%0d %h %h", j, i, rd_alog[i], wr_cyc[i], wr_alog[i], wr_dlog[i], 16'(sb + 16'(i)), 4 + i, exp_a[i], exp_q[i]); end
      end
      n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != l + 4) begin n_fail++; $display("FAIL rand%0d_done got %0d pulses want 1 at %0d", j, done_cyc.size(), l + 4); end
    end
  endtask

  task automatic test_async_reset;
    start_job(16'($urandom), 16'($urandom), 16'd6, 1'b0);
    step(7);                         // cycle 8, in DRAIN with a write under way
    n_tests++; if ({busy, wr_en} !== 2'b11) begin n_fail++; $display("FAIL areset_pre got %b want 11", {busy, wr_en}); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({busy, done, rd_en, sig_en, wr_en} !== 5'b0) begin n_fail++; $display("FAIL areset_ctrl got %b want 00000", {busy, done, rd_en, sig_en, wr_en}); end
    n_tests++; if ({rd_addr, wr_addr, wr_data, sig_in} !== 96'h0) begin n_fail++; $display("FAIL areset_data got %h want 0", {rd_addr, wr_addr, wr_data, sig_in}); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    step(12);
    n_tests++; if (wr_cyc.size() != 0 || done_cyc.size() != 0 || busy_cyc.size() != 0) begin n_fail++; $display("FAIL areset_after got %0d writes %0d done %0d busy want 0", wr_cyc.size(), done_cyc.size(), busy_cyc.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; deriv = 1'b0;
    src_base = '0; dst_base = '0; len = '0;
    test_reset();
    test_basic();
    test_deriv();
    test_zero_len();
    test_abort();
    test_abort_last();
    test_wrap();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
